// File: rtl/fifo_pkg.sv
// Shared types and elaboration-time helpers for the parametrised synchronous FIFO.
package fifo_pkg;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } rd_mode_e;

    // Smallest w with 2**w >= depth.
    function automatic int unsigned addr_width(input int unsigned depth);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < 31; i++) begin
            if ((32'd1 << i) < depth) w = i + 1;
        end
        return w;
    endfunction

    function automatic bit depth_ok(input int unsigned depth);
        return (depth >= 4) && ((depth & (depth - 1)) == 0);
    endfunction

    function automatic bit thresh_ok(input int unsigned depth,
                                     input int unsigned af,
                                     input int unsigned ae);
        return (af >= 1) && (af <= depth) && (ae <= depth - 1);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned AW     = 5
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with standard or first-word-fall-through read,
// live occupancy, synchronous flush and sticky overflow/underflow flags.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned DEPTH     = 32,
    parameter int unsigned FWFT      = 0,
    parameter int unsigned AF_THRESH = DEPTH - 1,
    parameter int unsigned AE_THRESH = 1,
    localparam int unsigned AW       = addr_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [AW:0]       count,
    output logic              overflow,
    output logic              underflow,
    input  logic              clr_err
);

    localparam rd_mode_e    MODE   = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;
    localparam logic [AW:0] CNT_MAX = (AW + 1)'(DEPTH);
    localparam logic [AW:0] AF_LVL  = (AW + 1)'(AF_THRESH);
    localparam logic [AW:0] AE_LVL  = (AW + 1)'(AE_THRESH);

    if (!depth_ok(DEPTH)) begin : g_bad_depth
        $error("sync_fifo_param: DEPTH must be a power of two and >= 4");
    end
    if (!thresh_ok(DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_thresh
        $error("sync_fifo_param: AF_THRESH/AE_THRESH out of range");
    end

    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic [AW:0]       count_q;
    logic [DATA_W-1:0] ram_rdata;
    logic              wa;
    logic              ra;
    logic              ram_we;

    // Flags decode the registered count only, never the live requests.
    assign full         = (count_q == CNT_MAX);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_LVL);
    assign almost_empty = (count_q <= AE_LVL);
    assign count        = count_q;

    assign wa     = wr_en && !full;
    assign ra     = rd_en && !empty;
    assign ram_we = wa && !flush && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            count_q   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            // Error detection still runs in a flush cycle; a new event beats clr_err.
            if (wr_en && full)  overflow <= 1'b1;
            else if (clr_err)   overflow <= 1'b0;
            if (rd_en && empty) underflow <= 1'b1;
            else if (clr_err)   underflow <= 1'b0;

            if (flush) begin
                wptr    <= '0;
                rptr    <= '0;
                count_q <= '0;
            end else begin
                if (wa) wptr <= wptr + AW'(1);
                if (ra) rptr <= rptr + AW'(1);
                unique case ({wa, ra})
                    2'b10:   count_q <= count_q + (AW + 1)'(1);
                    2'b01:   count_q <= count_q - (AW + 1)'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    fifo_ram #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .waddr(wptr),
        .wdata(wr_data),
        .raddr(rptr),
        .rdata(ram_rdata)
    );

    if (MODE == FIFO_STD) begin : g_std
        logic [DATA_W-1:0] rd_data_q;
        logic              rd_valid_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else if (flush) begin
                rd_valid_q <= 1'b0;
            end else begin
                rd_valid_q <= ra;
                if (ra) rd_data_q <= ram_rdata;
            end
        end

        assign rd_data  = rd_data_q;
        assign rd_valid = rd_valid_q;
    end else begin : g_fwft
        assign rd_data  = ram_rdata;
        assign rd_valid = !empty;
    end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised single-clock FIFO and the next generation of the team's 8-bit/32-entry synchronous FIFO. Width, depth and almost-thresholds are configurable. Adds a first-word-fall-through (FWFT) read mode, correct occupancy on simultaneous read and write, a synchronous flush, a live occupancy count and sticky overflow/underflow error flags. Sits between producer and consumer datapaths in the same clock domain.

Parameters:
DATA_W, 8, data width in bits (>=1)
DEPTH, 32, number of entries; power of two, >=4
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through
AF_THRESH, DEPTH-1, almost_full asserts when count >= AF_THRESH (1..DEPTH)
AE_THRESH, 1, almost_empty asserts when count <= AE_THRESH (0..DEPTH-1)

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
flush  in  1  synchronous clear of contents; error flags retained
wr_en  in  1  write request
wr_data  in  DATA_W  write data
rd_en  in  1  read request (standard) / pop (FWFT)
rd_data  out  DATA_W  read data
rd_valid  out  1  rd_data holds valid data (see Behaviour)
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_THRESH
almost_empty  out  1  count <= AE_THRESH
count  out  AW+1  occupancy, AW = log2(DEPTH)
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: read attempted while empty
clr_err  in  1  synchronous clear of overflow/underflow

Behaviour:
- Reset: wptr=rptr=0, count=0, rd_data=0, rd_valid=0, overflow=underflow=0. Outputs therefore read empty=1, full=0, almost_empty=1 (AE_THRESH>=0), almost_full=0. Memory array is not reset.
- Flags are combinational decodes of the registered count only. They never depend on the same-cycle wr_en/rd_en.
- Write accepted (wa) iff wr_en && !full. On accept: mem[wptr]<=wr_data and wptr++ modulo DEPTH, with natural wrap of an AW-bit pointer.
- Read accepted (ra) iff rd_en && !empty. On accept: rptr++ modulo DEPTH.
- count next = count + wa - ra. Simultaneous wa and ra leave count unchanged. full+rd+wr: only the read is accepted and the write is rejected. empty+rd+wr: only the write is accepted.
- Standard mode (FWFT=0):
  - On ra, rd_data<=mem[rptr] and rd_valid<=1 at the next edge (1-cycle latency).
  - Without ra, rd_valid<=0 and rd_data holds its last value.
- FWFT mode (FWFT=1):
  - rd_data = mem[rptr] combinationally; rd_valid = !empty; rd_en pops the head.
  - A write into an empty FIFO is visible (rd_valid=1) the cycle after the write edge.
  - rd_data is undefined while rd_valid=0.
- overflow<=1 on wr_en && full. underflow<=1 on rd_en && empty. Both stay set until rst or clr_err. If clr_err coincides with a new error event, set wins.
- flush: wptr=rptr=0, count=0, rd_valid=0 at the next edge. It overrides wr_en/rd_en in the same cycle, and nothing is written or read. rd_data holds its value in standard mode. Error flags are unaffected, apart from the flush-cycle error detection, which still applies.
- rst overrides flush, clr_err and all requests. Reset mid-burst discards contents, and no write in the reset cycle is committed.
- Count width AW+1 holds DEPTH exactly. No wrap of count is possible by construction.

Decomposition:
- Shared package fifo_pkg holds:
  - the address-width helper function (log2 of DEPTH);
  - parameter-legality checks (DEPTH power of two, threshold ranges), used as elaboration-time assertions;
  - the enum for read mode (FIFO_STD, FIFO_FWFT).
- One sub-module, fifo_ram: simple dual-port memory with DATA_W x DEPTH, one synchronous write port and one asynchronous read port addressed by rptr.
- Pointer, count, flag and error logic stays in sync_fifo_param.

Test Plan:
- Reset, then write 0x11..0x30 (32 words, DEPTH=32, FWFT=0): full=1 after the 32nd write and almost_full=1 at count=31. Then read 32 words: rd_data sequence 0x11..0x30, each with rd_valid one cycle after rd_en, and empty=1 at the end.
- At count=10, assert wr_en and rd_en together for 5 cycles: count stays 10 throughout and data order is preserved across the pointer wrap at entry 31->0.
- Full FIFO, wr_en=1 with data 0xAA: overflow=1 next cycle, count stays 32 and 0xAA is never read. Then clr_err: overflow=0. Empty FIFO with rd_en=1: underflow=1 and rd_valid=0.
- FWFT=1, single write of 0x5C into an empty FIFO: next cycle rd_valid=1 and rd_data=0x5C with no rd_en. Then rd_en for one cycle: empty=1 and rd_valid=0.
- At count=7, flush with wr_en=1 in the same cycle: count=0 and empty=1 next cycle. A subsequent write of 0x01 reads back 0x01, with no stale data returned.
- Assert rst mid-burst at count=20 with wr_en held high: the next cycle shows count=0, empty=1, rd_valid=0 and rd_data=0, and the reset-cycle write is not stored.
